// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// datapath mux selects and ALU operation codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_SLL  = 4'h2;
  localparam logic [3:0] ALU_SLT  = 4'h3;
  localparam logic [3:0] ALU_SLTU = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_OR   = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'h9;

  // Per-state control bundle; the ALU decoder supplies ALUControl/DataType.
  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_LOAD:   imm = IMM_I;
      OP_I:      imm = IMM_I;
      OP_STORE:  imm = IMM_S;
      OP_BRANCH: imm = IMM_B;
      OP_JAL:    imm = IMM_J;
      default:   imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation and memory access width decoder, shared with the single-cycle core.
module ALUDecoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct75,
  input  logic       op5,
  output logic [3:0] alu_control,
  output logic [1:0] data_type
);

  // op5 separates R-type sub from addi whose immediate happens to have bit 30 set.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (op5 && funct75) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: begin
            if (funct75) begin
              alu_control = ALU_SRA;
            end else begin
              alu_control = ALU_SRL;
            end
          end
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Load/store width follows funct3[1:0]: byte, half, word.
  always_comb begin
    data_type = funct3[1:0];
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the shared multicycle RV32I datapath: one memory port,
// one ALU, registered IR/OldPC/ALUOut/Data, stalls on mem_ready.
module multicycle_control
  import mc_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct75,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic [1:0] DataType,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state_r;
  state_t     state_next_s;
  ctrl_t      ctrl_s;
  ctrl_t      ctrl_out_s;
  logic [1:0] alu_op_s;
  logic [3:0] alu_control_s;
  logic [1:0] data_type_s;
  logic       quiet_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RESET_STATE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; mem_ready only matters in the three memory-access states.
  always_comb begin
    state_next_s = S_TRAP;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LOAD:   state_next_s = S_MEMADR;
          OP_STORE:  state_next_s = S_MEMADR;
          OP_R:      state_next_s = S_EXEC_R;
          OP_I:      state_next_s = S_EXEC_I;
          OP_BRANCH: state_next_s = S_BRANCH;
          OP_JAL:    state_next_s = S_JAL;
          default:   state_next_s = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        if (op[5]) begin
          state_next_s = S_MEMWRITE;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        if (mem_ready) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMWB:  state_next_s = S_FETCH;
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_EXEC_R: state_next_s = S_ALUWB;
      S_EXEC_I: state_next_s = S_ALUWB;
      S_ALUWB:  state_next_s = S_FETCH;
      S_BRANCH: state_next_s = S_FETCH;
      S_JAL:    state_next_s = S_ALUWB;
      S_TRAP:   state_next_s = S_TRAP;
      default:  state_next_s = S_TRAP;
    endcase
  end

  // Per-state control outputs; anything not set stays 0.
  always_comb begin
    ctrl_s         = '0;
    alu_op_s       = ALUOP_ADD;
    ctrl_s.imm_src = imm_src_of(op);
    case (state_r)
      S_FETCH: begin
        ctrl_s.mem_req    = 1'b1;
        ctrl_s.adr_src    = 1'b0;
        ctrl_s.alu_src_a  = SRCA_PC;
        ctrl_s.alu_src_b  = SRCB_FOUR;
        ctrl_s.result_src = RES_ALURESULT;
        if (mem_ready) begin
          ctrl_s.ir_write = 1'b1;
          ctrl_s.pc_write = 1'b1;
        end else begin
          ctrl_s.ir_write = 1'b0;
          ctrl_s.pc_write = 1'b0;
        end
      end
      S_DECODE: begin
        // Precompute the branch/JAL target into ALUOut.
        ctrl_s.alu_src_a = SRCA_OLDPC;
        ctrl_s.alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        ctrl_s.alu_src_a = SRCA_RS1;
        ctrl_s.alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        ctrl_s.mem_req = 1'b1;
        ctrl_s.adr_src = 1'b1;
      end
      S_MEMWB: begin
        ctrl_s.result_src = RES_DATA;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl_s.mem_req    = 1'b1;
        ctrl_s.adr_src    = 1'b1;
        ctrl_s.mem_write  = 1'b1;
        ctrl_s.instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ctrl_s.alu_src_a = SRCA_RS1;
        ctrl_s.alu_src_b = SRCB_RS2;
        alu_op_s         = ALUOP_FUNCT;
      end
      S_EXEC_I: begin
        ctrl_s.alu_src_a = SRCA_RS1;
        ctrl_s.alu_src_b = SRCB_IMM;
        alu_op_s         = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl_s.result_src = RES_ALUOUT;
        ctrl_s.reg_write  = 1'b1;
        ctrl_s.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_s.alu_src_a  = SRCA_RS1;
        ctrl_s.alu_src_b  = SRCB_RS2;
        alu_op_s          = ALUOP_SUB;
        ctrl_s.result_src = RES_ALUOUT;
        ctrl_s.pc_write   = funct3[0] ? !Zero : Zero;
        ctrl_s.instr_done = 1'b1;
      end
      S_JAL: begin
        // ALU forms the link OldPC+4 while the PC takes the target from ALUOut.
        ctrl_s.alu_src_a  = SRCA_OLDPC;
        ctrl_s.alu_src_b  = SRCB_FOUR;
        ctrl_s.result_src = RES_ALUOUT;
        ctrl_s.pc_write   = 1'b1;
      end
      S_TRAP: begin
        ctrl_s         = '0;
        ctrl_s.illegal = 1'b1;
      end
      default: begin
        ctrl_s         = '0;
        ctrl_s.illegal = 1'b1;
      end
    endcase
  end

  ALUDecoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (funct3),
    .funct75     (funct75),
    .op5         (op[5]),
    .alu_control (alu_control_s),
    .data_type   (data_type_s)
  );

  // Reset silences everything at once (an in-flight access is abandoned); a trap keeps only illegal.
  always_comb begin
    quiet_s = !rst_n || ctrl_s.illegal;
    if (rst_n) begin
      ctrl_out_s = ctrl_s;
    end else begin
      ctrl_out_s = '0;
    end
  end

  assign mem_req    = ctrl_out_s.mem_req;
  assign AdrSrc     = ctrl_out_s.adr_src;
  assign IRWrite    = ctrl_out_s.ir_write;
  assign PCWrite    = ctrl_out_s.pc_write;
  assign MemWrite   = ctrl_out_s.mem_write;
  assign RegWrite   = ctrl_out_s.reg_write;
  assign ResultSrc  = ctrl_out_s.result_src;
  assign ALUSrcA    = ctrl_out_s.alu_src_a;
  assign ALUSrcB    = ctrl_out_s.alu_src_b;
  assign ImmSrc     = ctrl_out_s.imm_src;
  assign instr_done = ctrl_out_s.instr_done;
  assign illegal    = ctrl_out_s.illegal;
  assign ALUControl = quiet_s ? 4'h0 : alu_control_s;
  assign DataType   = quiet_s ? 2'b00 : data_type_s;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control: walks each instruction class
// cycle by cycle against hand-computed control vectors.
module tb_multicycle_control;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct75;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, DataType;
  logic [3:0] ALUControl;
  logic       instr_done, illegal;
  logic [21:0] obs;
  int total = 0;
  int bad   = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct75(funct75),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .DataType(DataType), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ImmSrc, ALUControl, DataType, instr_done, illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // ctl = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite}
  task automatic exp_o(input string tag, input logic [5:0] ctl, input logic [1:0] rs,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
                       input logic [3:0] aluc, input logic [1:0] dt, input logic done,
                       input logic ill);
    #1;
    check_eq(tag, {10'd0, obs}, {10'd0, ctl, rs, sa, sb, imm, aluc, dt, done, ill});
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // FETCH with mem_ready=1, then advance into DECODE.
  task automatic do_fetch(input string tag, input logic [1:0] imm, input logic [1:0] dt);
    mem_ready = 1'b1;
    exp_o(tag, 6'b101100, 2'b10, 2'b00, 2'b10, imm, 4'h0, dt, 1'b0, 1'b0);
    cyc;
    mem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; op = OP_R; funct3 = 3'b000; funct75 = 1'b1; Zero = 1'b0;
    exp_o("rst_hold", 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    repeat (2) cyc;
    exp_o("rst_hold2", 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1; mem_ready = 1'b0;
    exp_o("fetch_wait", 6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cyc;
    exp_o("fetch_wait2", 6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);

    // sub x3,x1,x2
    do_fetch("sub_f", 2'b00, 2'b00);
    exp_o("sub_dec", 6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cyc;
    exp_o("sub_exec", 6'b000000, 2'b00, 2'b10, 2'b00, 2'b00, 4'h1, 2'b00, 1'b0, 1'b0);
    cyc;
    exp_o("sub_wb", 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b1, 1'b0);
    cyc;

    // addi with IR[30] set must still add
    op = OP_I; funct3 = 3'b000; funct75 = 1'b1;
    do_fetch("addi_f", 2'b00, 2'b00);
    exp_o("addi_dec", 6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cyc;
    exp_o("addi_exec", 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cyc;
    exp_o("addi_wb", 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b1, 1'b0);
    cyc;

    // lw with two wait cycles in MEMREAD
    op = OP_LOAD; funct3 = 3'b010; funct75 = 1'b0;
    do_fetch("lw_f", 2'b00, 2'b10);
    exp_o("lw_dec", 6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 2'b10, 1'b0, 1'b0);
    cyc;
    exp_o("lw_adr", 6'b000000, 2'b00, 2'b10, 2'b01, 2'b00, 4'h0, 2'b10, 1'b0, 1'b0);
    cyc;
    exp_o("lw_rd0", 6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b10, 1'b0, 1'b0);
    cyc;
    exp_o("lw_rd1", 6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b10, 1'b0, 1'b0);
    cyc;
    mem_ready = 1'b1;
    exp_o("lw_rd2", 6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b10, 1'b0, 1'b0);
    cyc;
    mem_ready = 1'b0;
    exp_o("lw_wb", 6'b000001, 2'b01, 2'b00, 2'b00, 2'b00, 4'h0, 2'b10, 1'b1, 1'b0);
    cyc;
    exp_o("lw_back", 6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 2'b10, 1'b0, 1'b0);

    // sw with one wait cycle in MEMWRITE
    op = OP_STORE; funct3 = 3'b010;
    do_fetch("sw_f", 2'b01, 2'b10);
    exp_o("sw_dec", 6'b000000, 2'b00, 2'b01, 2'b01, 2'b01, 4'h0, 2'b10, 1'b0, 1'b0);
    cyc;
    exp_o("sw_adr", 6'b000000, 2'b00, 2'b10, 2'b01, 2'b01, 4'h0, 2'b10, 1'b0, 1'b0);
    cyc;
    exp_o("sw_wr0", 6'b110010, 2'b00, 2'b00, 2'b00, 2'b01, 4'h0, 2'b10, 1'b0, 1'b0);
    mem_ready = 1'b1;
    exp_o("sw_wr1", 6'b110010, 2'b00, 2'b00, 2'b00, 2'b01, 4'h0, 2'b10, 1'b1, 1'b0);
    cyc;
    mem_ready = 1'b0;
    exp_o("sw_back", 6'b100000, 2'b10, 2'b00, 2'b10, 2'b01, 4'h0, 2'b10, 1'b0, 1'b0);

    // bne: taken when Zero=0
    op = OP_BRANCH; funct3 = 3'b001; Zero = 1'b0;
    do_fetch("bne_f", 2'b10, 2'b01);
    exp_o("bne_dec", 6'b000000, 2'b00, 2'b01, 2'b01, 2'b10, 4'h0, 2'b01, 1'b0, 1'b0);
    cyc;
    exp_o("bne_z0", 6'b000100, 2'b00, 2'b10, 2'b00, 2'b10, 4'h1, 2'b01, 1'b1, 1'b0);
    Zero = 1'b1;
    exp_o("bne_z1", 6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 4'h1, 2'b01, 1'b1, 1'b0);
    cyc;
    Zero = 1'b0;

    // beq: taken when Zero=1
    funct3 = 3'b000;
    do_fetch("beq_f", 2'b10, 2'b00);
    exp_o("beq_dec", 6'b000000, 2'b00, 2'b01, 2'b01, 2'b10, 4'h0, 2'b00, 1'b0, 1'b0);
    cyc;
    exp_o("beq_z0", 6'b000000, 2'b00, 2'b10, 2'b00, 2'b10, 4'h1, 2'b00, 1'b1, 1'b0);
    Zero = 1'b1;
    exp_o("beq_z1", 6'b000100, 2'b00, 2'b10, 2'b00, 2'b10, 4'h1, 2'b00, 1'b1, 1'b0);
    cyc;
    Zero = 1'b0;

    // jal
    op = OP_JAL; funct3 = 3'b000;
    do_fetch("jal_f", 2'b11, 2'b00);
    exp_o("jal_dec", 6'b000000, 2'b00, 2'b01, 2'b01, 2'b11, 4'h0, 2'b00, 1'b0, 1'b0);
    cyc;
    exp_o("jal_j", 6'b000100, 2'b00, 2'b01, 2'b10, 2'b11, 4'h0, 2'b00, 1'b0, 1'b0);
    cyc;
    exp_o("jal_wb", 6'b000001, 2'b00, 2'b00, 2'b00, 2'b11, 4'h0, 2'b00, 1'b1, 1'b0);
    cyc;

    // reset in the middle of a load read
    op = OP_LOAD; funct3 = 3'b010;
    do_fetch("lw2_f", 2'b00, 2'b10);
    cyc;
    cyc;
    exp_o("lw2_rd", 6'b110000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b10, 1'b0, 1'b0);
    rst_n = 1'b0;
    exp_o("lw2_rst", 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cyc;
    rst_n = 1'b1;
    exp_o("lw2_rel", 6'b100000, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 2'b10, 1'b0, 1'b0);

    // illegal opcode traps until reset
    op = 7'b1111111; funct3 = 3'b000;
    do_fetch("trap_f", 2'b00, 2'b00);
    exp_o("trap_dec", 6'b000000, 2'b00, 2'b01, 2'b01, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc;
      mem_ready = i[0];
      Zero = i[1];
      exp_o("trap_hold", 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b1);
    end
    rst_n = 1'b0;
    exp_o("trap_rst", 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);
    cyc;
    rst_n = 1'b1; mem_ready = 1'b1;
    exp_o("trap_rel", 6'b101100, 2'b10, 2'b00, 2'b10, 2'b00, 4'h0, 2'b00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM controller that sequences the shared multicycle RV32I datapath.
- The datapath has one unified memory port, one ALU used for PC+4, branch target and execute, and registered IR/OldPC/ALUOut/Data.
- Issues per-state mux selects, write enables and memory requests, and stalls on a memory ready handshake.
- Sits beside the datapath top in place of the single-cycle control unit.

Parameters:
- RESET_STATE, S_FETCH, state entered on reset (kept for sim/test override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  opcode from the IR.
- funct3  in  3  IR[14:12].
- funct75  in  1  IR[30].
- Zero  in  1  ALU zero flag, combinational, valid in the current cycle.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- AdrSrc  out  1  0=PC, 1=ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- MemWrite  out  1  store enable, valid only with mem_req.
- RegWrite  out  1  register file write.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1.
- ALUSrcB  out  2  00=rs2, 01=imm, 10=const 4.
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J.
- ALUControl  out  4  ALU operation.
- DataType  out  2  load/store width.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  high while in S_TRAP.

Behaviour:
Reset and state register:
- Asynchronous reset on rst_n low: state <= RESET_STATE.
- While rst_n=0, every output is forced to 0. This includes mem_req, even though the state is S_FETCH.
- Outputs are combinational from state, plus op/funct3/Zero/mem_ready where noted.
- Every signal not listed for a state is 0. Default ALUOp=00.

ALUOp (internal):
- 00 = add, 01 = subtract.
- 10 = decode funct3/funct75.

States:
- S_FETCH:
  - Outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - When mem_ready=1, also IRWrite=1 and PCWrite=1, then go to S_DECODE.
  - Otherwise stay in S_FETCH with IRWrite=PCWrite=0.
- S_DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01 (branch/JAL target into ALUOut).
  - Next state by op:
    - 0000011 or 0100011 -> S_MEMADR.
    - 0110011 -> S_EXEC_R.
    - 0010011 -> S_EXEC_I.
    - 1100011 -> S_BRANCH.
    - 1101111 -> S_JAL.
    - any other op -> S_TRAP.
- S_MEMADR:
  - Outputs: ALUSrcA=10, ALUSrcB=01.
  - Next: op[5]=0 -> S_MEMREAD, else S_MEMWRITE.
- S_MEMREAD:
  - Outputs: mem_req=1, AdrSrc=1.
  - Wait for mem_ready, then go to S_MEMWB.
- S_MEMWB:
  - Outputs: ResultSrc=01, RegWrite=1, instr_done=1.
  - Next: S_FETCH.
- S_MEMWRITE:
  - Outputs: mem_req=1, AdrSrc=1, MemWrite=1, held until mem_ready.
  - On mem_ready: instr_done=1, go to S_FETCH.
- S_EXEC_R:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - Next: S_ALUWB.
- S_EXEC_I:
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - Next: S_ALUWB.
- S_ALUWB:
  - Outputs: ResultSrc=00, RegWrite=1, instr_done=1.
  - Next: S_FETCH.
- S_BRANCH:
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = funct3[0] ? !Zero : Zero, which covers beq/bne.
  - Outputs: instr_done=1.
  - Next: S_FETCH.
- S_JAL:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1.
  - ALUResult = OldPC+4; the PC is loaded from the target held in ALUOut.
  - Next: S_ALUWB (link written there).
- S_TRAP:
  - Outputs: illegal=1, all others 0.
  - Stays in S_TRAP until reset.

Decode rules:
- ImmSrc is decoded from op in every state: I/load 00, store 01, branch 10, jal 11, other 00.
- ALUControl and DataType come from the ALU decoder sub-module, driven by ALUOp, funct3 and funct75.

Latency without memory wait states:
- lw = 5 cycles.
- sw = 4 cycles.
- R/I = 4 cycles.
- branch = 3 cycles.
- jal = 4 cycles.
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Boundary conditions:
- Reset asserted mid-access: mem_req drops immediately and the access is abandoned. The memory side must tolerate this.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Decomposition:
- Package mc_pkg holds:
  - state_t enum (4-bit) with S_FETCH..S_TRAP;
  - opcode constants OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL;
  - ALUOp, ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings.
- Sub-module: the existing ALUDecoder, instantiated unchanged for ALUControl/DataType.
- The FSM itself stays one module, with separate next-state and output always_comb blocks.

Test Plan:
- Reset: hold rst_n=0 with mem_ready=1 -> all outputs 0. Release -> mem_req=1, AdrSrc=0 in S_FETCH.
- add x3,x1,x2 (op 0110011), mem_ready=1 -> states FETCH, DECODE, EXEC_R, ALUWB. RegWrite=1 only in cycle 4, instr_done pulse in cycle 4, back to FETCH.
- lw (op 0000011) with 2 wait cycles in MEMREAD -> 7 cycles total. mem_req=1 and AdrSrc=1 for 3 cycles. RegWrite with ResultSrc=01 exactly once.
- sw (op 0100011) -> MemWrite=1 only in MEMWRITE, ImmSrc=01 throughout, no RegWrite.
- bne (funct3=001): Zero=0 -> PCWrite=1 in BRANCH. Zero=1 -> PCWrite=0. beq reverses both.
- op=1111111 -> DECODE to TRAP. illegal=1, PCWrite/RegWrite/mem_req stay 0 for 20 cycles until rst_n pulses.
